// File: rtl/ex_muldiv_if.sv
// Issue/writeback interface of the EX-stage multiply/divide unit.
// The master is the issuing pipeline; the slave is ex_muldiv.
interface ex_muldiv_if #(
   parameter int XLEN = 32
);
   logic            rdy;
   logic            valid_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] reg1_i;
   logic [XLEN-1:0] reg2_i;
   logic [4:0]      wd_i;
   logic            wreg_i;
   logic            flush_i;
   logic            stallreq;
   logic            valid_o;
   logic [4:0]      wd_o;
   logic            wreg_o;
   logic [XLEN-1:0] wdata_o;

   modport master (
      output rdy, valid_i, op_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      input  stallreq, valid_o, wd_o, wreg_o, wdata_o
   );

   modport slave (
      input  rdy, valid_i, op_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      output stallreq, valid_o, wd_o, wreg_o, wdata_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// RV32M-style multiply/divide unit: pipelined multiplier plus a restoring
// divider FSM, one op in flight, registered result with its writeback tag.
module ex_muldiv #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   ex_muldiv_if.slave bus
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DIV_FIX = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            idle, accept, busy_mul;
   logic            div_zero, div_ovf, div_sgn;
   logic            acc_mul, acc_div, acc_spc;
   logic [XLEN-1:0] spc_res;

   logic                   a_sgn, b_sgn;
   logic signed [2*XLEN-1:0] mul_a, mul_b, mul_prod;
   logic [XLEN-1:0]        mul_res;

   logic            mul_vld_last;
   logic [XLEN-1:0] mul_res_last;
   logic [4:0]      mul_wd_last;
   logic            mul_wreg_last;

   logic [XLEN-1:0] quo, rem, dvs, div_res;
   logic            q_neg, r_neg, d_rem, d_wreg;
   logic [4:0]      d_wd;
   logic [XLEN:0]   rem_sh, rem_diff;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return neg_if(v, sgn & v[XLEN-1]);
   endfunction

   // DONE counts as idle so a new op can issue in the result cycle.
   assign idle     = (state == IDLE || state == DONE) && !busy_mul;
   assign accept   = bus.rdy && bus.valid_i && !bus.flush_i && idle;
   assign div_sgn  = ~bus.op_i[0];
   assign div_zero = (bus.reg2_i == '0);
   assign div_ovf  = div_sgn && (bus.reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.reg2_i == '1);
   assign acc_mul  = accept && !bus.op_i[2];
   assign acc_div  = accept && bus.op_i[2] && !(div_zero || div_ovf);
   assign acc_spc  = accept && bus.op_i[2] && (div_zero || div_ovf);
   assign spc_res  = bus.op_i[1] ? (div_zero ? bus.reg1_i : '0)
                                 : (div_zero ? '1 : bus.reg1_i);

   // Operands extended to 2*XLEN: the product modulo 2^(2*XLEN) is exact.
   always_comb begin
      a_sgn    = (bus.op_i[1:0] == 2'd1) || (bus.op_i[1:0] == 2'd2);
      b_sgn    = (bus.op_i[1:0] == 2'd1);
      mul_a    = $signed({{XLEN{a_sgn & bus.reg1_i[XLEN-1]}}, bus.reg1_i});
      mul_b    = $signed({{XLEN{b_sgn & bus.reg2_i[XLEN-1]}}, bus.reg2_i});
      mul_prod = mul_a * mul_b;
      mul_res  = (bus.op_i[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
   end

   generate
      if (MUL_STAGES == 1) begin : g_mul_direct
         assign mul_vld_last  = acc_mul;
         assign mul_res_last  = mul_res;
         assign mul_wd_last   = bus.wd_i;
         assign mul_wreg_last = bus.wreg_i;
         assign busy_mul      = 1'b0;
      end else begin : g_mul_pipe
         localparam int D = MUL_STAGES - 1;
         logic [D-1:0]    vld_p;
         logic [D-1:0]    wreg_p;
         logic [XLEN-1:0] res_p [D];
         logic [4:0]      wd_p  [D];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_p <= '0;
            end else if (bus.rdy) begin
               for (int i = D-1; i > 0; i--) vld_p[i] <= vld_p[i-1];
               vld_p[0] <= acc_mul;
               if (bus.flush_i) vld_p <= '0;
            end
         end

         always_ff @(posedge clk) begin
            if (bus.rdy) begin
               for (int i = D-1; i > 0; i--) begin
                  res_p[i]  <= res_p[i-1];
                  wd_p[i]   <= wd_p[i-1];
                  wreg_p[i] <= wreg_p[i-1];
               end
               res_p[0]  <= mul_res;
               wd_p[0]   <= bus.wd_i;
               wreg_p[0] <= bus.wreg_i;
            end
         end

         assign mul_vld_last  = vld_p[D-1];
         assign mul_res_last  = res_p[D-1];
         assign mul_wd_last   = wd_p[D-1];
         assign mul_wreg_last = wreg_p[D-1];
         assign busy_mul      = |vld_p;
      end
   endgenerate

   // Restoring step: shift next dividend bit in, keep the difference if non-negative.
   always_comb begin
      rem_sh   = {rem, quo[XLEN-1]};
      rem_diff = rem_sh - {1'b0, dvs};
   end

   always_ff @(posedge clk) begin
      if (bus.rdy) begin
         if (acc_div) begin
            quo    <= mag(bus.reg1_i, div_sgn);
            rem    <= '0;
            dvs    <= mag(bus.reg2_i, div_sgn);
            q_neg  <= div_sgn & (bus.reg1_i[XLEN-1] ^ bus.reg2_i[XLEN-1]);
            r_neg  <= div_sgn & bus.reg1_i[XLEN-1];
            d_rem  <= bus.op_i[1];
            d_wd   <= bus.wd_i;
            d_wreg <= bus.wreg_i;
         end else if (state == DIV_RUN) begin
            if (rem_diff[XLEN]) begin
               rem <= rem_sh[XLEN-1:0];
               quo <= {quo[XLEN-2:0], 1'b0};
            end else begin
               rem <= rem_diff[XLEN-1:0];
               quo <= {quo[XLEN-2:0], 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (bus.rdy) begin
         if (bus.flush_i || state != DIV_RUN || cnt == CW'(XLEN-1)) cnt <= '0;
         else                                                     cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         state <= IDLE;
      else if (bus.rdy) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = acc_div ? DIV_RUN : IDLE;
         DIV_RUN:    if (cnt == CW'(XLEN-1)) state_nxt = DIV_FIX;
         DIV_FIX:    state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (bus.flush_i) state_nxt = IDLE;
   end

   always_comb begin
      bus.stallreq = (bus.valid_i && !bus.flush_i && idle) || busy_mul ||
                     (state == DIV_RUN) || (state == DIV_FIX);
      div_res      = d_rem ? neg_if(rem, r_neg) : neg_if(quo, q_neg);
   end

   // Result register: zero whenever nothing completes this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.valid_o <= 1'b0;
         bus.wreg_o  <= 1'b0;
         bus.wd_o    <= '0;
         bus.wdata_o <= '0;
      end else if (bus.rdy) begin
         bus.valid_o <= 1'b0;
         bus.wreg_o  <= 1'b0;
         bus.wd_o    <= '0;
         bus.wdata_o <= '0;
         if (!bus.flush_i) begin
            if (mul_vld_last) begin
               bus.valid_o <= 1'b1;
               bus.wreg_o  <= mul_wreg_last;
               bus.wd_o    <= mul_wd_last;
               bus.wdata_o <= mul_res_last;
            end else if (state == DIV_FIX) begin
               bus.valid_o <= 1'b1;
               bus.wreg_o  <= d_wreg;
               bus.wd_o    <= d_wd;
               bus.wdata_o <= div_res;
            end else if (acc_spc) begin
               bus.valid_o <= 1'b1;
               bus.wreg_o  <= bus.wreg_i;
               bus.wd_o    <= bus.wd_i;
               bus.wdata_o <= spc_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed results, latencies and stall
// windows for multiply, divide, special cases, flush, rdy freeze and reset.
module tb_ex_muldiv;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   ex_muldiv_if #(.XLEN(XLEN)) bus ();

   ex_muldiv #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.op_i    = 3'd0;
      bus.reg1_i  = '0;
      bus.reg2_i  = '0;
      bus.wd_i    = 5'd0;
      bus.wreg_i  = 1'b0;
   endtask

   task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd);
      bus.valid_i = 1'b1;
      bus.op_i    = op;
      bus.reg1_i  = a;
      bus.reg2_i  = b;
      bus.wd_i    = wd;
      bus.wreg_i  = 1'b1;
   endtask

   // Entered in the offer cycle; returns at the negedge of the result cycle.
   task automatic expect_result(input string tag, input bit same_cycle, input int exp_lat,
                                input logic [31:0] exp_data, input logic [4:0] exp_wd);
      int lat;
      int stalls;
      lat    = -1;
      stalls = 0;
      for (int k = 0; k <= 60; k++) begin
         if (k == 0 && same_cycle) #1;
         else                      @(negedge clk);
         if (k > 0 && bus.valid_o) begin
            lat = k;
            break;
         end
         if (bus.stallreq) stalls++;
         @(posedge clk);
         #1;
         bus.valid_i = 1'b0;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      if (lat > 0) begin
         check({tag, "_wdata"}, 64'(bus.wdata_o), 64'(exp_data));
         check({tag, "_wd"}, 64'(bus.wd_o), 64'(exp_wd));
         check({tag, "_wreg"}, 64'(bus.wreg_o), 64'(1'b1));
         check({tag, "_stall_done"}, 64'(bus.stallreq), 64'(1'b0));
      end
      check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
   endtask

   initial begin
      int vcnt;
      int lat;
      quiet();
      bus.rdy = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(bus.valid_o), 64'(1'b0));
      check("rst_wreg", 64'(bus.wreg_o), 64'(1'b0));
      check("rst_wd", 64'(bus.wd_o), 64'(5'd0));
      check("rst_wdata", 64'(bus.wdata_o), 64'(32'h0));
      check("rst_stall", 64'(bus.stallreq), 64'(1'b0));
      step();
      rst = 1'b1;

      step(); offer(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5);
      expect_result("mulh", 1'b0, 2, 32'h4000_0000, 5'd5);
      step();
      @(negedge clk);
      check("idle_valid", 64'(bus.valid_o), 64'(1'b0));
      check("idle_wreg", 64'(bus.wreg_o), 64'(1'b0));
      check("idle_wdata", 64'(bus.wdata_o), 64'(32'h0));

      step(); offer(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd6);
      expect_result("mul", 1'b0, 2, 32'h0000_0000, 5'd6);
      step(); offer(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7);
      expect_result("mulhsu", 1'b0, 2, 32'hFFFF_FFFF, 5'd7);
      step(); offer(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
      expect_result("mulhu", 1'b0, 2, 32'hFFFF_FFFE, 5'd8);

      step(); offer(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9);
      expect_result("div_neg", 1'b0, 34, 32'hFFFF_FFFD, 5'd9);
      step(); offer(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10);
      expect_result("rem_neg", 1'b0, 34, 32'hFFFF_FFFF, 5'd10);
      step(); offer(3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 5'd16);
      expect_result("divu_big", 1'b0, 34, 32'h7FFF_FFFF, 5'd16);
      step(); offer(3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd17);
      expect_result("rem_pos_dividend", 1'b0, 34, 32'h0000_0001, 5'd17);

      step(); offer(3'd5, 32'h0000_1234, 32'h0000_0000, 5'd11);
      expect_result("divu_by0", 1'b0, 1, 32'hFFFF_FFFF, 5'd11);
      step(); offer(3'd7, 32'h0000_1234, 32'h0000_0000, 5'd12);
      expect_result("remu_by0", 1'b0, 1, 32'h0000_1234, 5'd12);
      step(); offer(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
      expect_result("div_ovf", 1'b0, 1, 32'h8000_0000, 5'd13);
      step(); offer(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
      expect_result("rem_ovf", 1'b0, 1, 32'h0000_0000, 5'd14);

      // New op offered in the result cycle of the previous one.
      offer(3'd0, 32'h0000_0003, 32'h0000_0005, 5'd15);
      expect_result("b2b_mul", 1'b1, 2, 32'h0000_000F, 5'd15);

      step(); offer(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18);
      bus.flush_i = 1'b1;
      #1;
      check("flush_prio_stall", 64'(bus.stallreq), 64'(1'b0));
      step(); quiet();
      vcnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.valid_o) vcnt++;
         step();
      end
      check("flush_prio_no_valid", 64'(vcnt), 64'(0));

      offer(3'd5, 32'd100, 32'd7, 5'd19);
      step(); quiet();
      vcnt = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (bus.valid_o) vcnt++;
         step();
      end
      bus.flush_i = 1'b1;
      @(negedge clk);
      if (bus.valid_o) vcnt++;
      step();
      bus.flush_i = 1'b0;
      offer(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20);
      expect_result("post_flush_mulhu", 1'b0, 2, 32'hFFFF_FFFE, 5'd20);
      check("flushed_div_no_valid", 64'(vcnt), 64'(0));

      step(); offer(3'd5, 32'd100, 32'd7, 5'd21);
      step(); quiet();
      lat = -1;
      for (int k = 1; k <= 80; k++) begin
         bus.rdy = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (k == 7) check("rdy_low_stall", 64'(bus.stallreq), 64'(1'b1));
         if (bus.valid_o) begin
            lat = k;
            break;
         end
         step();
      end
      check("rdy_freeze_latency", 64'(lat), 64'(39));
      check("rdy_freeze_wdata", 64'(bus.wdata_o), 64'(32'd14));
      check("rdy_freeze_wd", 64'(bus.wd_o), 64'(5'd21));

      step(); bus.rdy = 1'b1;
      offer(3'd5, 32'd100, 32'd7, 5'd22);
      step(); quiet();
      repeat (4) step();
      check("pre_rst_stall", 64'(bus.stallreq), 64'(1'b1));
      rst = 1'b0;
      #1;
      check("midrst_valid", 64'(bus.valid_o), 64'(1'b0));
      check("midrst_wreg", 64'(bus.wreg_o), 64'(1'b0));
      check("midrst_wd", 64'(bus.wd_o), 64'(5'd0));
      check("midrst_wdata", 64'(bus.wdata_o), 64'(32'h0));
      check("midrst_stall", 64'(bus.stallreq), 64'(1'b0));
      step();
      rst = 1'b1;
      vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.valid_o) vcnt++;
         step();
      end
      check("post_rst_no_valid", 64'(vcnt), 64'(0));
      offer(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23);
      expect_result("post_rst_mulhu", 1'b0, 2, 32'hFFFF_FFFE, 5'd23);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
